rom_sweep_driver: RTL and testbench

ROM_SWEEP_DRIVER -- requirements
Module: rom_sweep_driver

---
 rtl/rom_sweep_driver.sv | 124 ++++++++++++
 tb/tb_rom_sweep_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sweep_driver.sv
// Sweeps a packed 16-bit ROM address vector through a combinational datapath,
// waits a fixed settle time per step and hands each result to a consumer.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, abort            sweep request (IDLE only) / unconditional stop
//   cfg_base, cfg_count     first address vector and number of steps
//   rom1_in..rom6_in        address slices of the current vector
//   result_in               datapath result for the current addresses
//   out_valid/out_ready     result handshake; out_data, out_idx payload
//   busy, done              not-idle flag, one-cycle completion pulse
module rom_sweep_driver #(
    parameter int SIZE       = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [15:0]     cfg_base,
    input  logic [7:0]      cfg_count,
    output logic [4:0]      rom1_in,
    output logic [1:0]      rom2_in,
    output logic [1:0]      rom3_in,
    output logic [1:0]      rom4_in,
    output logic [1:0]      rom5_in,
    output logic [2:0]      rom6_in,
    input  logic [SIZE-1:0] result_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic [7:0]      out_idx,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e          state_q;
    logic [3:0]      settle_q;
    logic [15:0]     vec_q;
    logic [7:0]      rem_q;
    logic [7:0]      idx_q;
    logic [SIZE-1:0] data_q;
    logic [7:0]      oidx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            vec_q    <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            oidx_q   <= '0;
        end else if (abort) begin
            // Abort beats everything; the vector is kept so the ROM
            // addresses hold their last value.
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_count == 8'd0) begin
                            state_q <= DONE;
                        end else begin
                            vec_q    <= cfg_base;
                            rem_q    <= cfg_count;
                            idx_q    <= '0;
                            settle_q <= '0;
                            state_q  <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    settle_q <= settle_q + 4'd1;
                    if (settle_q == SETTLE_LAST) begin
                        data_q  <= result_in;
                        oidx_q  <= idx_q;
                        state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (rem_q == 8'd1) begin
                            state_q <= DONE;
                        end else begin
                            vec_q    <= vec_q + 16'd1;
                            rem_q    <= rem_q - 8'd1;
                            idx_q    <= idx_q + 8'd1;
                            settle_q <= '0;
                            state_q  <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status flags are pure decodes of the registered state.
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_data  = data_q;
    assign out_idx   = oidx_q;

    assign rom1_in = vec_q[15:11];
    assign rom2_in = vec_q[10:9];
    assign rom3_in = vec_q[8:7];
    assign rom4_in = vec_q[6:5];
    assign rom5_in = vec_q[4:3];
    assign rom6_in = vec_q[2:0];

endmodule

// File: tb/tb_rom_sweep_driver.sv
// Directed bench for rom_sweep_driver with a queue-based result scoreboard.
// Stimulus pushes expected steps; a monitor pops them on each handshake.
module tb_rom_sweep_driver;

    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [15:0]     cfg_base = '0;
    logic [7:0]      cfg_count = '0;
    logic [4:0]      rom1_in;
    logic [1:0]      rom2_in, rom3_in, rom4_in, rom5_in;
    logic [2:0]      rom6_in;
    logic [SIZE-1:0] result_in;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SIZE-1:0] out_data;
    logic [7:0]      out_idx;
    logic            busy;
    logic            done;

    rom_sweep_driver #(.SIZE(SIZE), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_base(cfg_base), .cfg_count(cfg_count),
        .rom1_in(rom1_in), .rom2_in(rom2_in), .rom3_in(rom3_in),
        .rom4_in(rom4_in), .rom5_in(rom5_in), .rom6_in(rom6_in),
        .result_in(result_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_vec;
    assign rom_vec = {rom1_in, rom2_in, rom3_in, rom4_in, rom5_in, rom6_in};
    // Datapath stand-in: echo the address vector back as the result.
    assign result_in = {16'h0000, rom_vec};

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   valid_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: checks the payload that the next edge accepts.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {56'd0, out_idx}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_idx", {56'd0, out_idx}, {56'd0, e.idx});
                chk("out_data", {32'd0, out_data}, {48'd0, e.vec});
                chk("rom_vec", {48'd0, rom_vec}, {48'd0, e.vec});
            end
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (out_valid) valid_cnt++;
    end

    task automatic run_sweep(input logic [15:0] base, input logic [7:0] cnt,
                             input int nexp);
        @(posedge clk); #1;
        cfg_base = base;
        cfg_count = cnt;
        start = 1'b1;
        for (int i = 0; i < nexp; i++) begin
            exp_t e;
            e.idx = 8'(i);
            e.vec = base + 16'(i);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {63'd0, n < 200}, 64'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", {63'd0, n < 50}, 64'd1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_outs"},
            {out_valid, busy, done, out_idx, rom_vec},
            64'd0);
        chk({nm, "_data"}, {32'd0, out_data}, 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three-step sweep from 0 with ready held high
        out_ready = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        valid_cnt = 0;
        run_sweep(16'h0000, 8'd3, 3);
        wait_idle();
        chk("basic_busy_cycles", busy_cnt, 10);
        chk("basic_done_pulses", done_cnt, 1);
        chk("basic_valid_cycles", valid_cnt, 3);
        chk("basic_queue_empty", exp_q.size(), 0);

        // Wrap from 0xFFFF to 0x0000
        run_sweep(16'hFFFF, 8'd2, 2);
        wait_valid();
        chk("wrap_rom1_max", {59'd0, rom1_in}, 64'd31);
        chk("wrap_rom6_max", {61'd0, rom6_in}, 64'd7);
        wait_idle();
        chk("wrap_final_vec", {48'd0, rom_vec}, 64'd0);
        chk("wrap_queue_empty", exp_q.size(), 0);

        // Back-pressure: hold ready low for five cycles during step 0
        out_ready = 1'b0;
        run_sweep(16'h1234, 8'd2, 2);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_payload", {out_idx, out_data, rom_vec},
                {8'd0, 32'h0000_1234, 16'h1234});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
        chk("hold_queue_empty", exp_q.size(), 0);

        // Zero-length sweep
        busy_cnt = 0;
        done_cnt = 0;
        valid_cnt = 0;
        run_sweep(16'h5555, 8'd0, 0);
        @(negedge clk);
        chk("zero_done_now", {63'd0, done}, 64'd1);
        wait_idle();
        chk("zero_done_pulses", done_cnt, 1);
        chk("zero_no_valid", valid_cnt, 0);
        chk("zero_busy_cycles", busy_cnt, 1);

        // Start together with abort in IDLE stays idle
        @(posedge clk); #1;
        cfg_count = 8'd2;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", {63'd0, busy}, 64'd0);

        // Abort in SETTLE of step 1 of 4
        done_cnt = 0;
        run_sweep(16'h0100, 8'd4, 1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(out_valid && out_ready) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("abort_hs_timeout", {63'd0, n < 50}, 64'd1);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_flags", {61'd0, busy, out_valid, done}, 64'd0);
        chk("abort_vec_kept", {48'd0, rom_vec}, 64'h0101);
        chk("abort_no_done", done_cnt, 0);
        run_sweep(16'h0100, 8'd1, 1);
        wait_idle();
        chk("abort_rerun_empty", exp_q.size(), 0);

        // Start during busy ignored, then async reset in OUTPUT
        out_ready = 1'b0;
        run_sweep(16'h0042, 8'd2, 0);
        cfg_base = 16'h9999;
        cfg_count = 8'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid();
        chk("busy_start_ignored", {out_idx, rom_vec, out_data},
            {8'd0, 16'h0042, 32'h0000_0042});
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_wait_idle", {62'd0, busy, out_valid}, 64'd0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
